// File: rtl/cert_chain_fetch_ctrl.sv
// Certificate chain fetch sequencer: requests each certificate of a chain from a
// slot, validates the response header, hands it to a comparator and tracks progress.
module cert_chain_fetch_ctrl #(
   parameter int NUM_SLOTS   = 8,
   parameter int MAX_CERTS   = 8,
   parameter int TIMEOUT_CYC = 1024,
   parameter int MAX_RETRY   = 2,
   localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
   localparam int CNT_W      = $clog2(MAX_CERTS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [SLOT_W-1:0] slot,
   input  logic [CNT_W-1:0]  num_certs,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [SLOT_W-1:0] req_slot,
   output logic [CNT_W-1:0]  req_index,
   input  logic              rsp_valid,
   input  logic [15:0]       rsp_hdr,
   output logic              cmp_start,
   input  logic              cmp_done,
   input  logic              cmp_pass,
   output logic              busy,
   output logic              done,
   output logic              failed,
   output logic [1:0]        fail_code,
   output logic [CNT_W-1:0]  cert_count
);

   localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [15:0] CERT_HDR = 16'h0182;
   // Request-to-request spacing on timeout is TIMEOUT_CYC cycles, the re-issue cycle included.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 2);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_RSP, S_CHECK, S_NEXT, S_DONE, S_FAIL
   } state_t;

   state_t            state_q, state_d;
   logic              req_valid_q, req_valid_d;
   logic              cmp_start_q, cmp_start_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              failed_q, failed_d;
   logic [1:0]        fail_code_q, fail_code_d;
   logic [CNT_W-1:0]  cert_count_q, cert_count_d;
   logic [SLOT_W-1:0] req_slot_q, req_slot_d;
   logic [CNT_W-1:0]  req_index_q, req_index_d;
   logic [CNT_W-1:0]  num_certs_q, num_certs_d;
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [RTY_W-1:0]  retry_q, retry_d;
   logic              go_fail;
   logic [1:0]        go_code;
   logic              start_legal;

   assign start_legal = (num_certs != '0) && (int'(num_certs) <= MAX_CERTS)
                        && (int'(slot) < NUM_SLOTS);

   always_comb begin
      state_d      = state_q;
      req_valid_d  = req_valid_q;
      cmp_start_d  = 1'b0;
      done_d       = done_q;
      failed_d     = failed_q;
      fail_code_d  = fail_code_q;
      cert_count_d = cert_count_q;
      req_slot_d   = req_slot_q;
      req_index_d  = req_index_q;
      num_certs_d  = num_certs_q;
      tmo_cnt_d    = tmo_cnt_q;
      retry_d      = retry_q;
      go_fail      = 1'b0;
      go_code      = 2'd0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (start_legal) begin
                  req_slot_d   = slot;
                  num_certs_d  = num_certs;
                  req_index_d  = '0;
                  cert_count_d = '0;
                  retry_d      = '0;
                  done_d       = 1'b0;
                  failed_d     = 1'b0;
                  fail_code_d  = 2'd0;
                  req_valid_d  = 1'b1;
                  state_d      = S_ISSUE;
               end else begin
                  go_fail = 1'b1;
                  go_code = 2'd3;
               end
            end
         end
         S_ISSUE: begin
            if (req_valid_q && req_ready) begin
               req_valid_d = 1'b0;
               tmo_cnt_d   = '0;
               state_d     = S_WAIT_RSP;
            end
         end
         S_WAIT_RSP: begin
            if (rsp_valid) begin
               if (rsp_hdr == CERT_HDR) begin
                  cmp_start_d = 1'b1;
                  state_d     = S_CHECK;
               end else begin
                  go_fail = 1'b1;
                  go_code = 2'd1;
               end
            end else if (tmo_cnt_q == TMO_LAST) begin
               if (retry_q < RTY_MAX) begin
                  retry_d     = retry_q + RTY_W'(1);
                  req_valid_d = 1'b1;
                  state_d     = S_ISSUE;
               end else begin
                  go_fail = 1'b1;
                  go_code = 2'd2;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         S_CHECK: begin
            if (cmp_done) begin
               if (cmp_pass) begin
                  cert_count_d = cert_count_q + CNT_W'(1);
                  state_d      = S_NEXT;
               end else begin
                  go_fail = 1'b1;
                  go_code = 2'd0;
               end
            end
         end
         S_NEXT: begin
            if (cert_count_q == num_certs_q) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               req_index_d = cert_count_q;
               retry_d     = '0;
               req_valid_d = 1'b1;
               state_d     = S_ISSUE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_FAIL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (go_fail) begin
         state_d     = S_FAIL;
         failed_d    = 1'b1;
         fail_code_d = go_code;
         done_d      = 1'b0;
         req_valid_d = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         req_valid_q  <= 1'b0;
         cmp_start_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         failed_q     <= 1'b0;
         fail_code_q  <= 2'd0;
         cert_count_q <= '0;
         req_slot_q   <= '0;
         req_index_q  <= '0;
         num_certs_q  <= '0;
         tmo_cnt_q    <= '0;
         retry_q      <= '0;
      end else begin
         state_q      <= state_d;
         req_valid_q  <= req_valid_d;
         cmp_start_q  <= cmp_start_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         failed_q     <= failed_d;
         fail_code_q  <= fail_code_d;
         cert_count_q <= cert_count_d;
         req_slot_q   <= req_slot_d;
         req_index_q  <= req_index_d;
         num_certs_q  <= num_certs_d;
         tmo_cnt_q    <= tmo_cnt_d;
         retry_q      <= retry_d;
      end
   end

   assign req_valid  = req_valid_q;
   assign cmp_start  = cmp_start_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign failed     = failed_q;
   assign fail_code  = fail_code_q;
   assign cert_count = cert_count_q;
   assign req_slot   = req_slot_q;
   assign req_index  = req_index_q;

endmodule

// File: tb/tb_cert_chain_fetch_ctrl.sv
// Directed bench for cert_chain_fetch_ctrl: nominal chain, header/compare failures,
// timeout retries, illegal arguments, busy-start rejection and mid-operation reset.
module tb_cert_chain_fetch_ctrl;
   localparam int NUM_SLOTS   = 8;
   localparam int MAX_CERTS   = 8;
   localparam int TIMEOUT_CYC = 16;
   localparam int MAX_RETRY   = 2;
   localparam int SLOT_W      = 3;
   localparam int CNT_W       = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [SLOT_W-1:0] slot = '0;
   logic [CNT_W-1:0]  num_certs = '0;
   logic              req_valid;
   logic              req_ready = 1'b0;
   logic [SLOT_W-1:0] req_slot;
   logic [CNT_W-1:0]  req_index;
   logic              rsp_valid = 1'b0;
   logic [15:0]       rsp_hdr = 16'h0;
   logic              cmp_start;
   logic              cmp_done = 1'b0;
   logic              cmp_pass = 1'b0;
   logic              busy;
   logic              done;
   logic              failed;
   logic [1:0]        fail_code;
   logic [CNT_W-1:0]  cert_count;

   int n_pass  = 0;
   int n_total = 0;
   int req_idx[$];
   int req_cyc[$];
   int req_slt[$];
   int cmp_pulses;
   int end_cyc;
   bit fin;

   cert_chain_fetch_ctrl #(
      .NUM_SLOTS(NUM_SLOTS), .MAX_CERTS(MAX_CERTS),
      .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .slot(slot), .num_certs(num_certs),
      .req_valid(req_valid), .req_ready(req_ready), .req_slot(req_slot),
      .req_index(req_index), .rsp_valid(rsp_valid), .rsp_hdr(rsp_hdr),
      .cmp_start(cmp_start), .cmp_done(cmp_done), .cmp_pass(cmp_pass),
      .busy(busy), .done(done), .failed(failed), .fail_code(fail_code),
      .cert_count(cert_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_start(input logic [SLOT_W-1:0] s, input logic [CNT_W-1:0] n);
      step();
      start     = 1'b1;
      slot      = s;
      num_certs = n;
      step();
      start     = 1'b0;
   endtask

   // Responder: answers requests after a short delay, with optional bad header,
   // compare failure at one index, and a number of initial requests left unanswered.
   task automatic run_chain(input int bad_idx, input int fail_idx, input int silent_reqs,
                            input int budget);
      int rsp_wait;
      int cmp_wait;
      int cur_idx;
      int silent;
      rsp_wait = -1;
      cmp_wait = -1;
      cur_idx  = 0;
      silent   = silent_reqs;
      req_idx.delete();
      req_cyc.delete();
      req_slt.delete();
      cmp_pulses = 0;
      fin        = 1'b0;
      end_cyc    = -1;
      req_ready  = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if (done || failed) begin
            fin     = 1'b1;
            end_cyc = c;
            break;
         end
         rsp_valid = 1'b0;
         rsp_hdr   = 16'h0;
         cmp_done  = 1'b0;
         cmp_pass  = 1'b0;
         if (rsp_wait == 0) begin
            rsp_valid = 1'b1;
            rsp_hdr   = (cur_idx == bad_idx) ? 16'h0183 : 16'h0182;
            rsp_wait  = -1;
         end else if (rsp_wait > 0) begin
            rsp_wait--;
         end
         if (cmp_wait == 0) begin
            cmp_done = 1'b1;
            cmp_pass = (cur_idx != fail_idx);
            cmp_wait = -1;
         end else if (cmp_wait > 0) begin
            cmp_wait--;
         end
         if (req_valid) begin
            req_idx.push_back(int'(req_index));
            req_cyc.push_back(c);
            req_slt.push_back(int'(req_slot));
            cur_idx = int'(req_index);
            if (silent > 0) silent--;
            else rsp_wait = 2;
         end
         if (cmp_start) begin
            cmp_pulses++;
            cmp_wait = 1;
         end
         step();
      end
      rsp_valid = 1'b0;
      rsp_hdr   = 16'h0;
      cmp_done  = 1'b0;
      cmp_pass  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      n_total++;
      if ({req_valid, cmp_start, busy, done, failed, fail_code, cert_count, req_slot, req_index} !== '0) begin
         $display("FAIL reset_outputs: got %b expected all zero",
                  {req_valid, cmp_start, busy, done, failed, fail_code, cert_count, req_slot, req_index});
      end else n_pass++;
   endtask

   task automatic test_nominal();
      drive_start(3'd2, 4'd3);
      run_chain(-1, -1, 0, 300);
      n_total++;
      if (!fin) $display("FAIL nominal_finish: got no done/failed within budget, expected done");
      else n_pass++;
      n_total++;
      if (req_idx.size() != 3) $display("FAIL nominal_req_count: got %0d expected 3", req_idx.size());
      else n_pass++;
      for (int i = 0; i < req_idx.size(); i++) begin
         n_total++;
         if (req_idx[i] != i || req_slt[i] != 2)
            $display("FAIL nominal_req_%0d: got index %0d slot %0d expected index %0d slot 2",
                     i, req_idx[i], req_slt[i], i);
         else n_pass++;
      end
      n_total++;
      if (cmp_pulses != 3) $display("FAIL nominal_cmp_pulses: got %0d expected 3", cmp_pulses);
      else n_pass++;
      n_total++;
      if ({done, failed, fail_code, cert_count} !== {1'b1, 1'b0, 2'd0, 4'd3})
         $display("FAIL nominal_result: got done=%0b failed=%0b code=%0d count=%0d expected 1 0 0 3",
                  done, failed, fail_code, cert_count);
      else n_pass++;
      step();
      step();
      step();
      n_total++;
      if ({busy, done, failed, cert_count} !== {1'b0, 1'b1, 1'b0, 4'd3})
         $display("FAIL nominal_sticky: got busy=%0b done=%0b failed=%0b count=%0d expected 0 1 0 3",
                  busy, done, failed, cert_count);
      else n_pass++;
   endtask

   task automatic test_busy_start();
      req_ready = 1'b0;
      drive_start(3'd5, 4'd2);
      n_total++;
      if ({busy, done, req_valid} !== 3'b101)
         $display("FAIL busy_accept: got busy=%0b done=%0b req_valid=%0b expected 1 0 1", busy, done, req_valid);
      else n_pass++;
      start     = 1'b1;
      slot      = 3'd1;
      num_certs = 4'd1;
      step();
      step();
      step();
      start = 1'b0;
      n_total++;
      if ({req_valid, req_slot, req_index} !== {1'b1, 3'd5, 4'd0})
         $display("FAIL busy_hold: got valid=%0b slot=%0d index=%0d expected 1 5 0",
                  req_valid, req_slot, req_index);
      else n_pass++;
      run_chain(-1, -1, 0, 300);
      n_total++;
      if (!fin || req_idx.size() != 2 || req_slt[0] != 5 || req_slt[1] != 5 || req_idx[1] != 1)
         $display("FAIL busy_chain: got fin=%0b requests=%0d expected fin=1 requests=2 on slot 5",
                  fin, req_idx.size());
      else n_pass++;
      n_total++;
      if ({done, cert_count} !== {1'b1, 4'd2})
         $display("FAIL busy_result: got done=%0b count=%0d expected 1 2", done, cert_count);
      else n_pass++;
   endtask

   task automatic test_bad_header();
      drive_start(3'd1, 4'd2);
      run_chain(0, -1, 0, 300);
      n_total++;
      if (!fin || req_idx.size() != 1 || cmp_pulses != 0)
         $display("FAIL badhdr_flow: got fin=%0b requests=%0d cmp_pulses=%0d expected 1 1 0",
                  fin, req_idx.size(), cmp_pulses);
      else n_pass++;
      n_total++;
      if ({done, failed, fail_code, cert_count} !== {1'b0, 1'b1, 2'd1, 4'd0})
         $display("FAIL badhdr_result: got done=%0b failed=%0b code=%0d count=%0d expected 0 1 1 0",
                  done, failed, fail_code, cert_count);
      else n_pass++;
   endtask

   task automatic test_cmp_fail();
      drive_start(3'd3, 4'd4);
      run_chain(-1, 2, 0, 400);
      n_total++;
      if (!fin || req_idx.size() != 3 || cmp_pulses != 3)
         $display("FAIL cmpfail_flow: got fin=%0b requests=%0d cmp_pulses=%0d expected 1 3 3",
                  fin, req_idx.size(), cmp_pulses);
      else n_pass++;
      n_total++;
      if ({done, failed, fail_code, cert_count} !== {1'b0, 1'b1, 2'd0, 4'd2})
         $display("FAIL cmpfail_result: got done=%0b failed=%0b code=%0d count=%0d expected 0 1 0 2",
                  done, failed, fail_code, cert_count);
      else n_pass++;
   endtask

   task automatic test_timeout_fail();
      drive_start(3'd0, 4'd2);
      run_chain(-1, -1, 3, 200);
      n_total++;
      if (!fin || req_idx.size() != 3)
         $display("FAIL tmo_req_count: got fin=%0b requests=%0d expected 1 3", fin, req_idx.size());
      else n_pass++;
      if (req_idx.size() == 3) begin
         n_total++;
         if (req_idx[0] != 0 || req_idx[1] != 0 || req_idx[2] != 0)
            $display("FAIL tmo_req_index: got %0d %0d %0d expected 0 0 0", req_idx[0], req_idx[1], req_idx[2]);
         else n_pass++;
         n_total++;
         if (req_cyc[1] - req_cyc[0] != 16 || req_cyc[2] - req_cyc[1] != 16 || end_cyc - req_cyc[2] != 16)
            $display("FAIL tmo_spacing: got %0d %0d %0d expected 16 16 16",
                     req_cyc[1] - req_cyc[0], req_cyc[2] - req_cyc[1], end_cyc - req_cyc[2]);
         else n_pass++;
      end
      n_total++;
      if ({done, failed, fail_code, cert_count} !== {1'b0, 1'b1, 2'd2, 4'd0})
         $display("FAIL tmo_result: got done=%0b failed=%0b code=%0d count=%0d expected 0 1 2 0",
                  done, failed, fail_code, cert_count);
      else n_pass++;
   endtask

   task automatic test_timeout_recover();
      drive_start(3'd4, 4'd1);
      run_chain(-1, -1, 2, 200);
      n_total++;
      if (!fin || req_idx.size() != 3 || cmp_pulses != 1)
         $display("FAIL tmorec_flow: got fin=%0b requests=%0d cmp_pulses=%0d expected 1 3 1",
                  fin, req_idx.size(), cmp_pulses);
      else n_pass++;
      n_total++;
      if ({done, failed, fail_code, cert_count} !== {1'b1, 1'b0, 2'd0, 4'd1})
         $display("FAIL tmorec_result: got done=%0b failed=%0b code=%0d count=%0d expected 1 0 0 1",
                  done, failed, fail_code, cert_count);
      else n_pass++;
   endtask

   task automatic test_illegal_args();
      logic [CNT_W-1:0] bad_n [2];
      bad_n[0] = 4'd0;
      bad_n[1] = 4'd9;
      for (int k = 0; k < 2; k++) begin
         drive_start(3'd1, bad_n[k]);
         n_total++;
         if ({req_valid, done, failed, fail_code} !== {1'b0, 1'b0, 1'b1, 2'd3})
            $display("FAIL illegal_%0d: got valid=%0b done=%0b failed=%0b code=%0d expected 0 0 1 3",
                     bad_n[k], req_valid, done, failed, fail_code);
         else n_pass++;
         step();
         n_total++;
         if ({busy, req_valid, failed, fail_code} !== {1'b0, 1'b0, 1'b1, 2'd3})
            $display("FAIL illegal_idle_%0d: got busy=%0b valid=%0b failed=%0b code=%0d expected 0 0 1 3",
                     bad_n[k], busy, req_valid, failed, fail_code);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_op();
      req_ready = 1'b1;
      drive_start(3'd2, 4'd3);
      step();
      n_total++;
      if ({busy, req_valid} !== 2'b10)
         $display("FAIL rst_wait_pre: got busy=%0b valid=%0b expected 1 0", busy, req_valid);
      else n_pass++;
      reset = 1'b1;
      step();
      reset     = 1'b0;
      rsp_valid = 1'b1;
      rsp_hdr   = 16'h0182;
      cmp_done  = 1'b1;
      cmp_pass  = 1'b1;
      n_total++;
      if ({req_valid, cmp_start, busy, done, failed, fail_code, cert_count, req_slot, req_index} !== '0)
         $display("FAIL rst_wait: got %b expected all zero",
                  {req_valid, cmp_start, busy, done, failed, fail_code, cert_count, req_slot, req_index});
      else n_pass++;
      step();
      rsp_valid = 1'b0;
      cmp_done  = 1'b0;
      cmp_pass  = 1'b0;
      n_total++;
      if ({busy, cmp_start, done} !== 3'b000)
         $display("FAIL rst_wait_ignore: got busy=%0b cmp_start=%0b done=%0b expected 0 0 0", busy, cmp_start, done);
      else n_pass++;

      drive_start(3'd2, 4'd3);
      step();
      rsp_valid = 1'b1;
      rsp_hdr   = 16'h0182;
      step();
      rsp_valid = 1'b0;
      n_total++;
      if (cmp_start !== 1'b1) $display("FAIL rst_check_pre: got cmp_start=%0b expected 1", cmp_start);
      else n_pass++;
      reset = 1'b1;
      step();
      reset     = 1'b0;
      rsp_valid = 1'b1;
      cmp_done  = 1'b1;
      cmp_pass  = 1'b1;
      n_total++;
      if ({req_valid, cmp_start, busy, done, failed, fail_code, cert_count, req_slot, req_index} !== '0)
         $display("FAIL rst_check: got %b expected all zero",
                  {req_valid, cmp_start, busy, done, failed, fail_code, cert_count, req_slot, req_index});
      else n_pass++;
      step();
      rsp_valid = 1'b0;
      cmp_done  = 1'b0;
      cmp_pass  = 1'b0;
      n_total++;
      if ({busy, done, cert_count} !== {1'b0, 1'b0, 4'd0})
         $display("FAIL rst_check_ignore: got busy=%0b done=%0b count=%0d expected 0 0 0", busy, done, cert_count);
      else n_pass++;

      drive_start(3'd2, 4'd3);
      run_chain(-1, -1, 0, 300);
      n_total++;
      if (!fin || req_idx.size() != 3 || {done, failed, cert_count} !== {1'b1, 1'b0, 4'd3})
         $display("FAIL rst_recover: got fin=%0b requests=%0d done=%0b failed=%0b count=%0d expected 1 3 1 0 3",
                  fin, req_idx.size(), done, failed, cert_count);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_busy_start();
      test_bad_header();
      test_cmp_fail();
      test_timeout_fail();
      test_timeout_recover();
      test_illegal_args();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cert_chain_fetch_ctrl.md
CERT_CHAIN_FETCH_CTRL -- requirements
Module: cert_chain_fetch_ctrl

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8: number of certificate slots; SLOT_W = max(1, clog2(NUM_SLOTS)).
REQ-002 SHALL have parameter MAX_CERTS, default 8: maximum chain length; CNT_W = clog2(MAX_CERTS+1).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024: response wait limit in cycles.
REQ-004 SHALL have parameter MAX_RETRY, default 2: re-requests allowed per certificate after a timeout.
REQ-005 SHALL have ports: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-006 SHALL have ports: start input 1, start pulse; slot input SLOT_W, target slot; num_certs input CNT_W, chain length.
REQ-007 SHALL have ports: req_valid output 1; req_ready input 1; req_slot output SLOT_W; req_index output CNT_W, index of the certificate being requested.
REQ-008 SHALL have ports: rsp_valid input 1; rsp_hdr input 16, {ProtocolVersion[15:8], MessageType[7:0]}.
REQ-009 SHALL have ports: cmp_start output 1, one-cycle pulse; cmp_done input 1; cmp_pass input 1, valid when cmp_done=1.
REQ-010 SHALL have ports: busy output 1; done output 1; failed output 1; fail_code output 2; cert_count output CNT_W.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT_RSP, CHECK, NEXT, DONE, FAIL, all outputs registered on rising clk.
REQ-012 IDLE: start=1 with 1<=num_certs<=MAX_CERTS and slot<NUM_SLOTS -> latch slot/num_certs, clear cert_count/retry/done/failed, go ISSUE; start with an illegal argument -> FAIL with fail_code=3 next cycle.
REQ-013 ISSUE: req_valid=1 with req_slot/req_index stable; request transfers on a cycle where req_valid&req_ready -> WAIT_RSP and the timeout counter is cleared; req_valid SHALL deassert the cycle after the transfer.
REQ-014 WAIT_RSP: rsp_valid=1 and rsp_hdr==16'h0182 -> CHECK, cmp_start pulses exactly one cycle on entry; rsp_valid with any other header -> FAIL with fail_code=1.
REQ-015 WAIT_RSP: the timeout counter increments each cycle without rsp_valid; on reaching TIMEOUT_CYC with retry<MAX_RETRY -> retry+1 and back to ISSUE with the same index; with retry==MAX_RETRY -> FAIL with fail_code=2.
REQ-016 WAIT_RSP: rsp_valid on the same cycle as the timeout SHALL take precedence as a response.
REQ-017 CHECK: wait for cmp_done; cmp_pass=1 -> NEXT with cert_count+1; cmp_pass=0 -> FAIL with fail_code=0; rsp_valid is ignored while in CHECK.
REQ-018 NEXT: cert_count==num_certs -> DONE, else ISSUE with req_index=cert_count, retry cleared.
REQ-019 req_index SHALL equal cert_count (0-based) and SHALL never exceed MAX_CERTS-1.
REQ-020 DONE: done=1 and FAIL: failed=1, each held (sticky) until the next accepted start or reset; the same cycle returns to IDLE; done and failed are never high together.
REQ-021 busy=1 in every state except IDLE; start while busy=1 SHALL be ignored.
REQ-022 fail_code SHALL be 0 whenever failed=0.
REQ-023 cert_count SHALL hold its final value after DONE/FAIL until the next accepted start.

Reset
REQ-024 reset=1 at a clock edge SHALL force IDLE from any state, including mid-request and mid-compare.
REQ-025 Reset values: req_valid=0, cmp_start=0, busy=0, done=0, failed=0, fail_code=0, cert_count=0, req_slot=0, req_index=0; internal timeout/retry counters 0.
REQ-026 A pending cmp_done or rsp_valid arriving in the first cycle after reset SHALL be ignored.

Verification
REQ-027 Nominal: start, slot=2, num_certs=3, req_ready=1, every response hdr 16'h0182 with cmp_pass=1 -> three requests (index 0,1,2, req_slot=2), done=1, cert_count=3, failed=0.
REQ-028 Bad header: num_certs=2, first response hdr 16'h0183 -> failed=1, fail_code=1, cert_count=0, no cmp_start pulse.
REQ-029 Timeout/retry: TIMEOUT_CYC=16, MAX_RETRY=2, no response -> three requests for index 0, each 16 cycles apart, then failed=1, fail_code=2; a variant answering after the 2nd retry -> done.
REQ-030 Compare fail: num_certs=4, cmp_pass=0 on index 2 -> failed=1, fail_code=0, cert_count=2.
REQ-031 Illegal args: num_certs=0, or num_certs=MAX_CERTS+1 -> failed=1, fail_code=3 next cycle, no req_valid.
REQ-032 Reset mid-operation: assert reset while in WAIT_RSP, then while in CHECK -> all outputs at reset values next cycle; a subsequent nominal start completes normally.
